// File: rtl/ir_score_counter.sv
// IR hit scorer: synchronises and debounces one receiver line, turns each clean
// beam rising edge into a weighted hit, and accumulates a saturating 4-digit BCD score.
module ir_score_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BASE_POINTS     = 1,
  parameter int SNITCH_POINTS   = 10
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ir_raw,
  input  logic       enable,
  input  logic       clear_score,
  input  logic       snitch_powerup,
  input  logic       lightning_powerup,
  output logic       ir_filtered,
  output logic       hit_pulse,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [3:0] score_hundreds,
  output logic [3:0] score_thousands,
  output logic       score_saturated
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  // Per-hit point values are constants, so their BCD digits are fixed at elaboration.
  localparam int PB  = BASE_POINTS;
  localparam int PB2 = 2 * BASE_POINTS;
  localparam int PS  = SNITCH_POINTS;
  localparam int PS2 = 2 * SNITCH_POINTS;
  localparam logic [3:0] PB_T  = 4'(PB  / 10), PB_O  = 4'(PB  % 10);
  localparam logic [3:0] PB2_T = 4'(PB2 / 10), PB2_O = 4'(PB2 % 10);
  localparam logic [3:0] PS_T  = 4'(PS  / 10), PS_O  = 4'(PS  % 10);
  localparam logic [3:0] PS2_T = 4'(PS2 / 10), PS2_O = 4'(PS2 % 10);

  logic        sync1_q, sync2_q;
  logic [19:0] cnt_q, cnt_d;
  logic        filt_q, filt_d;
  logic        filt_dly_q;
  logic [3:0][3:0] score_q, score_d;
  logic        sat_q, sat_d;

  logic [3:0] pts_t, pts_o;
  logic [4:0] add0, add1, add2, add3;

  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (s >= 5'd10) bcd_add = {1'b1, 4'(s - 5'd10)};
    else            bcd_add = {1'b0, s[3:0]};
  endfunction

  // Counter only advances while the synchronised level disagrees with the filter.
  always_comb begin
    cnt_d  = 20'd0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = ~filt_q;
      else                   cnt_d  = cnt_q + 20'd1;
    end
  end

  assign hit_pulse = filt_q & ~filt_dly_q & enable;

  always_comb begin
    pts_t = PB_T;
    pts_o = PB_O;
    case ({snitch_powerup, lightning_powerup})
      2'b01:   begin pts_t = PB2_T; pts_o = PB2_O; end
      2'b10:   begin pts_t = PS_T;  pts_o = PS_O;  end
      2'b11:   begin pts_t = PS2_T; pts_o = PS2_O; end
      default: begin pts_t = PB_T;  pts_o = PB_O;  end
    endcase
  end

  assign add0 = bcd_add(score_q[0], pts_o, 1'b0);
  assign add1 = bcd_add(score_q[1], pts_t, add0[4]);
  assign add2 = bcd_add(score_q[2], 4'd0,  add1[4]);
  assign add3 = bcd_add(score_q[3], 4'd0,  add2[4]);

  // Clear wins over a same-cycle hit; carry out of the top digit clamps to 9999.
  always_comb begin
    score_d = score_q;
    sat_d   = sat_q;
    if (clear_score) begin
      score_d = '0;
      sat_d   = 1'b0;
    end else if (hit_pulse) begin
      if (add3[4]) begin
        score_d = {4'd9, 4'd9, 4'd9, 4'd9};
        sat_d   = 1'b1;
      end else begin
        score_d = {add3[3:0], add2[3:0], add1[3:0], add0[3:0]};
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= 20'd0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      score_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      sync1_q    <= ir_raw;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      score_q    <= score_d;
      sat_q      <= sat_d;
    end
  end

  assign ir_filtered     = filt_q;
  assign score_ones      = score_q[0];
  assign score_tens      = score_q[1];
  assign score_hundreds  = score_q[2];
  assign score_thousands = score_q[3];
  assign score_saturated = sat_q;

endmodule

// File: tb/tb_ir_score_counter.sv
// Directed bench for ir_score_counter with a 4-cycle debounce window.
module tb_ir_score_counter;
  logic clock = 1'b0;
  logic resetn, ir_raw, enable, clear_score, snitch_powerup, lightning_powerup;
  logic ir_filtered, hit_pulse, score_saturated;
  logic [3:0] score_ones, score_tens, score_hundreds, score_thousands;
  int checks = 0;
  int errors = 0;

  ir_score_counter #(.DEBOUNCE_CYCLES(4), .BASE_POINTS(1), .SNITCH_POINTS(10)) dut (
    .clock(clock), .resetn(resetn), .ir_raw(ir_raw), .enable(enable),
    .clear_score(clear_score), .snitch_powerup(snitch_powerup),
    .lightning_powerup(lightning_powerup), .ir_filtered(ir_filtered),
    .hit_pulse(hit_pulse), .score_ones(score_ones), .score_tens(score_tens),
    .score_hundreds(score_hundreds), .score_thousands(score_thousands),
    .score_saturated(score_saturated));

  always #5 clock = ~clock;

  function automatic logic [15:0] score();
    return {score_thousands, score_hundreds, score_tens, score_ones};
  endfunction

  task automatic hold(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clock);
      if (hit_pulse) pulses++;
    end
  endtask

  // One full beam hit: rise, held past the debounce, dropped and fully re-armed.
  task automatic do_hit(input logic s, input logic l, output int pulses);
    int p2;
    snitch_powerup = s; lightning_powerup = l;
    ir_raw = 1'b1;
    hold(10, pulses);
    ir_raw = 1'b0;
    hold(8, p2);
    pulses += p2;
    snitch_powerup = 1'b0; lightning_powerup = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock); clear_score = 1'b1;
    @(negedge clock); clear_score = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ir_raw = 1'b0; enable = 1'b1; clear_score = 1'b0;
    snitch_powerup = 1'b0; lightning_powerup = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({ir_filtered, hit_pulse, score_saturated, score()} !== 19'd0) begin
      errors++; $display("FAIL reset outputs got %h expected 0",
                         {ir_filtered, hit_pulse, score_saturated, score()});
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_hit();
    int pulses = 0;
    ir_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (hit_pulse) pulses++;
      if (i == 5) begin
        checks++;
        if (ir_filtered !== 1'b0) begin
          errors++; $display("FAIL filt_early got %b expected 0", ir_filtered);
        end
      end
      if (i == 6) begin
        checks++;
        if (ir_filtered !== 1'b1 || hit_pulse !== 1'b1) begin
          errors++; $display("FAIL filt_rise got filt=%b hit=%b expected 1 1", ir_filtered, hit_pulse);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL single_pulses got %0d expected 1", pulses); end
    checks++;
    if (score() !== 16'h0001) begin errors++; $display("FAIL single_score got %h expected 0001", score()); end
    ir_raw = 1'b0;
    hold(8, pulses);
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int filt_seen = 0;
    do_clear();
    for (int k = 0; k < 5; k++) begin
      ir_raw = 1'b1;
      repeat (3) begin @(negedge clock); if (hit_pulse) pulses++; if (ir_filtered) filt_seen++; end
      ir_raw = 1'b0;
      repeat (3) begin @(negedge clock); if (hit_pulse) pulses++; if (ir_filtered) filt_seen++; end
    end
    repeat (4) begin @(negedge clock); if (ir_filtered) filt_seen++; end
    checks++;
    if (filt_seen !== 0 || pulses !== 0) begin
      errors++; $display("FAIL glitch filt_cycles=%0d pulses=%0d expected 0 0", filt_seen, pulses);
    end
    checks++;
    if (score() !== 16'h0000) begin errors++; $display("FAIL glitch_score got %h expected 0000", score()); end
  endtask

  task automatic test_powerups();
    int p;
    do_clear();
    repeat (4) do_hit(1'b1, 1'b1, p);
    do_hit(1'b1, 1'b0, p);
    repeat (5) do_hit(1'b0, 1'b0, p);
    checks++;
    if (score() !== 16'h0095) begin errors++; $display("FAIL pu_setup got %h expected 0095", score()); end
    do_hit(1'b1, 1'b1, p);
    checks++;
    if (score() !== 16'h0115) begin errors++; $display("FAIL pu_x20 got %h expected 0115", score()); end
    do_hit(1'b0, 1'b1, p);
    checks++;
    if (score() !== 16'h0117) begin errors++; $display("FAIL pu_x2 got %h expected 0117", score()); end
    do_hit(1'b0, 1'b0, p);
    checks++;
    if (score() !== 16'h0118) begin errors++; $display("FAIL pu_base got %h expected 0118", score()); end
  endtask

  task automatic test_saturation();
    int p;
    do_clear();
    repeat (499) do_hit(1'b1, 1'b1, p);
    do_hit(1'b1, 1'b0, p);
    checks++;
    if (score() !== 16'h9990 || score_saturated !== 1'b0) begin
      errors++; $display("FAIL sat_setup got %h sat=%b expected 9990 0", score(), score_saturated);
    end
    do_hit(1'b1, 1'b0, p);
    checks++;
    if (score() !== 16'h9999 || score_saturated !== 1'b1) begin
      errors++; $display("FAIL sat_clamp got %h sat=%b expected 9999 1", score(), score_saturated);
    end
    do_hit(1'b0, 1'b0, p);
    checks++;
    if (p !== 1 || score() !== 16'h9999) begin
      errors++; $display("FAIL sat_hold got pulses=%0d score=%h expected 1 9999", p, score());
    end
    do_clear();
    checks++;
    if (score() !== 16'h0000 || score_saturated !== 1'b0) begin
      errors++; $display("FAIL sat_clear got %h sat=%b expected 0000 0", score(), score_saturated);
    end
  endtask

  task automatic test_enable_gate();
    int p;
    enable = 1'b0;
    ir_raw = 1'b1;
    hold(10, p);
    checks++;
    if (p !== 0 || ir_filtered !== 1'b1 || score() !== 16'h0000) begin
      errors++; $display("FAIL en_low got pulses=%0d filt=%b score=%h expected 0 1 0000", p, ir_filtered, score());
    end
    enable = 1'b1;
    hold(10, p);
    checks++;
    if (p !== 0 || score() !== 16'h0000) begin
      errors++; $display("FAIL en_rearm got pulses=%0d score=%h expected 0 0000", p, score());
    end
    ir_raw = 1'b0;
    hold(8, p);
    do_hit(1'b0, 1'b0, p);
    checks++;
    if (p !== 1 || score() !== 16'h0001) begin
      errors++; $display("FAIL en_after got pulses=%0d score=%h expected 1 0001", p, score());
    end
  endtask

  task automatic test_clear_collision();
    int p;
    do_clear();
    repeat (4) do_hit(1'b1, 1'b0, p);
    repeat (2) do_hit(1'b0, 1'b0, p);
    checks++;
    if (score() !== 16'h0042) begin errors++; $display("FAIL col_setup got %h expected 0042", score()); end
    ir_raw = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (hit_pulse !== 1'b1) begin errors++; $display("FAIL col_pulse got %b expected 1", hit_pulse); end
    clear_score = 1'b1;
    @(negedge clock);
    clear_score = 1'b0;
    checks++;
    if (score() !== 16'h0000 || score_saturated !== 1'b0) begin
      errors++; $display("FAIL col_score got %h expected 0000", score());
    end
    ir_raw = 1'b0;
    hold(8, p);
  endtask

  task automatic test_reset_mid_debounce();
    int p;
    do_hit(1'b0, 1'b0, p);
    ir_raw = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (score() !== 16'h0002 || ir_filtered !== 1'b1) begin
      errors++; $display("FAIL rst_setup got %h filt=%b expected 0002 1", score(), ir_filtered);
    end
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if ({ir_filtered, hit_pulse, score_saturated, score()} !== 19'd0) begin
      errors++; $display("FAIL rst_mid got %h expected 0", {ir_filtered, hit_pulse, score_saturated, score()});
    end
    resetn = 1'b1;
    hold(12, p);
    checks++;
    if (p !== 1 || score() !== 16'h0001 || ir_filtered !== 1'b1) begin
      errors++; $display("FAIL rst_rehit got pulses=%0d score=%h filt=%b expected 1 0001 1", p, score(), ir_filtered);
    end
    ir_raw = 1'b0;
    hold(8, p);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_glitch();
    test_powerups();
    test_saturation();
    test_enable_gate();
    test_clear_collision();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
